// File: rtl/alu_result_stage.sv
// alu_result_stage: registers ALU result + carry, derives ARM NZCV, queues results for write-back.
// Latency: 1 cycle from accepted push to out_valid (empty queue). Throughput: 1 op/cycle.
// Backpressure: 2-entry queue; in_ready is registered from occupancy only (no out_ready path).
//
// Ports:
//   clk, rst_n                      clock / async active-low reset
//   in_valid, in_ready              upstream handshake (push = in_valid && in_ready)
//   A, B, ALUControl                operands and op as seen by the ALU (00 ADD, 01 SUB, 10 XOR, 11 NOT)
//   alu_out, alu_cout               ALU result and carry-out
//   set_flags, rd_in                S bit and destination index
//   out_valid, out_ready            downstream handshake (pop = out_valid && out_ready)
//   result, rd_out, flags_out       head entry contents (flags_out = NZCV after that entry's update)
//   flags                           architectural NZCV register {N,Z,C,V}
module alu_result_stage #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic [1:0]   ALUControl,
  input  logic [N-1:0] alu_out,
  input  logic         alu_cout,
  input  logic         set_flags,
  input  logic [3:0]   rd_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] result,
  output logic [3:0]   rd_out,
  output logic [3:0]   flags_out,
  output logic [3:0]   flags
);

  localparam int MSB = N - 1;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;

  // Queue storage and control
  logic [N-1:0] res_q  [2];
  logic [3:0]   rd_q   [2];
  logic [3:0]   nzcv_q [2];
  logic         wr_ptr_q, rd_ptr_q;
  logic [1:0]   count_q, count_d;
  logic         in_ready_q;
  logic [3:0]   flags_q, flags_d;

  logic push, pop;
  logic n_f, z_f, c_f, v_f;

  // Only operand sign bits affect the flags; the low bits are intentionally unused.
  logic unused_operand_bits;
  assign unused_operand_bits = ^{A[MSB-1:0], B[MSB-1:0]};

  assign push = in_valid && in_ready_q;
  assign pop  = (count_q != 2'd0) && out_ready;

  // NZCV derivation. Logical ops keep the current C and V.
  always_comb begin
    n_f = alu_out[MSB];
    z_f = (alu_out == '0);
    c_f = flags_q[1];
    v_f = flags_q[0];
    case (ALUControl)
      OP_ADD: begin
        c_f = alu_cout;
        v_f = (A[MSB] == B[MSB]) && (alu_out[MSB] != A[MSB]);
      end
      OP_SUB: begin
        // Carry is "not borrow", straight from the ALU's A + ~B + 1.
        c_f = alu_cout;
        v_f = (A[MSB] != B[MSB]) && (alu_out[MSB] != A[MSB]);
      end
      default: begin
        c_f = flags_q[1];
        v_f = flags_q[0];
      end
    endcase
  end

  // Flags commit at acceptance, so the stored snapshot is in program order
  // regardless of how long the entry waits for write-back.
  always_comb begin
    flags_d = flags_q;
    if (push && set_flags) begin
      flags_d = {n_f, z_f, c_f, v_f};
    end
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        res_q[i]  <= '0;
        rd_q[i]   <= '0;
        nzcv_q[i] <= '0;
      end
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
      in_ready_q <= 1'b1;
      flags_q    <= 4'b0000;
    end else begin
      if (push) begin
        res_q[wr_ptr_q]  <= alu_out;
        rd_q[wr_ptr_q]   <= rd_in;
        nzcv_q[wr_ptr_q] <= flags_d;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q    <= count_d;
      // A pop while full frees a slot only from the next cycle onward.
      in_ready_q <= (count_d != 2'd2);
      flags_q    <= flags_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = (count_q != 2'd0);
  assign result    = res_q[rd_ptr_q];
  assign rd_out    = rd_q[rd_ptr_q];
  assign flags_out = nzcv_q[rd_ptr_q];
  assign flags     = flags_q;

endmodule

// File: doc/alu_result_stage.md
# alu_result_stage

Registered result and flags stage directly downstream of the flag-less ALU in the ARMv4 datapath. It captures the ALU's combinational result and carry-out together with the operands and opcode, and derives the ARM NZCV condition flags. It updates an architectural flag register when the instruction sets flags. Results are buffered in a 2-entry queue with a valid/ready handshake toward the write-back stage.

## Interface

- N, 4: datapath width; must match the ALU width; N >= 2.
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream presents a completed ALU operation.
- in_ready  out  1  stage can accept; registered, depends only on queue occupancy.
- A  in  N  ALU operand A as presented to the ALU.
- B  in  N  ALU operand B as presented to the ALU (before inversion).
- ALUControl  in  2  ALU op: 00 ADD, 01 SUB, 10 XOR, 11 NOT.
- alu_out  in  N  ALU result.
- alu_cout  in  1  ALU carry-out.
- set_flags  in  1  instruction S bit; 1 = update flag register.
- rd_in  in  4  destination register index, carried through.
- out_valid  out  1  head entry valid.
- out_ready  in  1  downstream accepts head entry.
- result  out  N  head entry result.
- rd_out  out  4  head entry destination index.
- flags_out  out  4  head entry NZCV snapshot {N,Z,C,V} after its own update.
- flags  out  4  architectural NZCV register {N,Z,C,V}.

## Operation

- Push occurs when in_valid && in_ready. Pop occurs when out_valid && out_ready.
- Queue: 2 entries, circular with 1-bit read/write pointers and a 2-bit count (0..2).
  - in_ready = (count != 2).
  - out_valid = (count != 0).
  - Push and pop in the same cycle: count unchanged, both pointers advance.
- Flag derivation at push time, with msb = bit N-1:
  - Nf = alu_out[msb].
  - Zf = (alu_out == 0).
  - ADD: C = alu_cout; V = (A[msb]==B[msb]) && (alu_out[msb]!=A[msb]).
  - SUB: C = alu_cout, so C=1 means no borrow; V = (A[msb]!=B[msb]) && (alu_out[msb]!=A[msb]).
  - XOR and NOT: C and V keep their current register values; only N and Z are recomputed.
- On push with set_flags=1, the flag register loads the derived NZCV. With set_flags=0, it is unchanged.
- Each entry stores the NZCV value the register holds after that push. For set_flags=0 this is the unchanged value. This gives write-back a program-ordered snapshot.
- Flags update on acceptance, not on pop. Back-pressure never reorders flag updates.
- Inputs are ignored when in_valid=0 or in_ready=0. Upstream must hold its inputs stable until accepted.
- Queue storage is not cleared on pop. result, rd_out and flags_out are don't-care while out_valid=0.

## Timing

- Latency: 1 cycle. An entry pushed at edge k is visible with out_valid=1 after edge k, when the queue was empty.
- Throughput: 1 operation per cycle while out_ready=1.
- in_ready is a registered function of count only; there is no combinational path from out_ready. At count=2, a pop in that cycle does not enable a same-cycle push; in_ready rises the following cycle.
- flags changes the cycle after the pushing edge. It is readable by the next instruction on the next push.
- Reset (asynchronous assert, synchronous deassert) gives: count=0, pointers=0, in_ready=1, out_valid=0, flags=4'b0000, result=0, rd_out=0, flags_out=0.
- Reset mid-operation: all queued entries are discarded and the flags register is cleared immediately, independent of clk.

## Test plan

- ADD, N=4: A=0111, B=0001, alu_out=1000, cout=0, set_flags=1 -> next cycle out_valid=1, result=1000, flags=flags_out=1001 (N=1, Z=0, C=0, V=1).
- SUB: A=0011, B=0011, alu_out=0000, cout=1, set_flags=1 -> flags=0110; then XOR A=0101, B=0101, alu_out=0000, set_flags=1 -> flags stays 0110 (C, V kept).
- set_flags=0 ADD producing 0000/cout=1 after flags=1001 -> flags stays 1001; entry flags_out=1001.
- Back-pressure: out_ready=0, push 3 ops on consecutive cycles -> only 2 accepted, in_ready=0 after the second. Raise out_ready for 1 cycle -> in_ready=1 the next cycle. Drain order matches push order.
- Simultaneous push/pop at count=1 with out_ready=1 and in_valid=1 for 5 cycles -> count stays 1, one result per cycle, in order.
- Assert rst_n=0 mid-cycle with count=2 and flags=1001 -> out_valid=0, in_ready=1, flags=0000 immediately, before the next clock edge.
